// File: rtl/product_bcd_converter_pkg.sv
// Shared constants and FSM encoding for the product-to-BCD converter.
package product_bcd_converter_pkg;

  localparam int PROD_W = 8;           // binary product width (4x4 multiply)
  localparam int DIGITS = 3;           // hundreds, tens, ones
  localparam int ITER   = 8;           // one double-dabble iteration per product bit
  localparam int BCD_W  = 4 * DIGITS;  // packed digit width
  localparam int CNT_W  = 4;           // iteration counter, holds 0..8 without wrapping

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD3  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Combinational add-3-if->=5 correction.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: turns an 8-bit unsigned product into
// three BCD digits in 8 ADD3/SHIFT iterations.
//
// Handshake: st is a start strobe sampled only while busy=0 (IDLE); it is
// normally wired straight to the multiplier's done, with product_i wired to
// the multiplier's product_o. product_i is captured on the accepting edge and
// ignored afterwards. busy is high from the cycle after acceptance until the
// DONE cycle inclusive; done pulses for exactly that DONE cycle, in which
// bcd_o already holds the new result. bcd_o holds its value until the next
// DONE (or reset).
module product_bcd_converter
  import product_bcd_converter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] product_i,
  input  logic              st,
  output logic [BCD_W-1:0]  bcd_o,
  output logic              busy,
  output logic              done,
  output state_e            dbg_state_o
);

  state_e             state_q, state_d;
  logic [PROD_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   scr_adj;

  // One add-3 corrector per decimal digit of the scratch register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (scr_q[4*g +: 4]),
      .digit_o (scr_adj[4*g +: 4])
    );
  end

  // Next-state and datapath: defaults hold every register first.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (st) begin
          bin_d   = product_i;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = ADD3;
        end
      end
      ADD3: begin
        scr_d   = scr_adj;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Scratch and binary shift together as one register.
        {scr_d, bin_d} = {scr_q, bin_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == CNT_W'(ITER)) begin
          // Result is loaded on entry to DONE so it is valid while done is high.
          bcd_d   = scr_d;
          state_d = DONE;
        end else begin
          state_d = ADD3;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign bcd_o       = bcd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: directed table, mid-conversion
// and reset corner cases, random values and a full 0..255 sweep against an
// arithmetic decimal reference.
module tb_product_bcd_converter;
  import product_bcd_converter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [7:0]  product_i;
  logic [11:0] bcd_o;
  logic        busy;
  logic        done;
  state_e      dbg_state_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [7:0]  prod;
    logic [11:0] exp_bcd;
  } vec_t;

  vec_t vecs[13];

  // Clock and DUT.
  always #5 clk = ~clk;

  product_bcd_converter dut (
    .clk         (clk),
    .rst         (rst),
    .product_i   (product_i),
    .st          (st),
    .bcd_o       (bcd_o),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state_o)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal digits straight from integer arithmetic.
  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Start one conversion and score it against the head of exp_q.
  task automatic run_conv(input logic [7:0] v, input string name);
    logic [11:0] exp;
    int          lat;
    bit          seen;
    product_i = v;
    st        = 1'b1;
    step();
    st = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      step();
      lat++;
      if (done) seen = 1'b1;
    end
    exp = exp_q.pop_front();
    check({name, "_latency"}, lat, 32'd16);
    check({name, "_bcd"}, 32'(bcd_o), 32'(exp));
    check({name, "_digit_range"},
          32'(bcd_o[3:0] <= 4'd9 && bcd_o[7:4] <= 4'd9 && bcd_o[11:8] <= 4'd2), 32'd1);
    step();
    check({name, "_done_single"}, 32'(done), 32'd0);
    check({name, "_idle_after"}, 32'(busy), 32'd0);
    check({name, "_hold"}, 32'(bcd_o), 32'(exp));
  endtask

  initial begin
    int          pulses;
    logic [11:0] got;
    logic [7:0]  rv;

    vecs[0]  = '{8'h00, 12'h000};
    vecs[1]  = '{8'hE1, 12'h225};
    vecs[2]  = '{8'hFF, 12'h255};
    vecs[3]  = '{8'h63, 12'h099};
    vecs[4]  = '{8'h01, 12'h001};
    vecs[5]  = '{8'h09, 12'h009};
    vecs[6]  = '{8'h0A, 12'h010};
    vecs[7]  = '{8'h64, 12'h100};
    vecs[8]  = '{8'hC7, 12'h199};
    vecs[9]  = '{8'hC8, 12'h200};
    vecs[10] = '{8'h0F, 12'h015};
    vecs[11] = '{8'h32, 12'h050};
    vecs[12] = '{8'h7B, 12'h123};

    // Reset state.
    rst       = 1'b1;
    st        = 1'b0;
    product_i = 8'h00;
    repeat (3) step();
    check("reset_bcd", 32'(bcd_o), 32'h000);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(dbg_state_o), 32'(IDLE));
    rst = 1'b0;
    step();

    // Idle with st low: nothing moves.
    repeat (3) step();
    check("idle_busy", 32'(busy), 32'd0);

    // Directed table; 0xFF is followed back-to-back by 0x63.
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(vecs[i].exp_bcd);
      run_conv(vecs[i].prod, $sformatf("vec%0d", i));
    end

    // st re-asserted with a new product mid-conversion is ignored.
    product_i = 8'h2A;
    st        = 1'b1;
    step();
    pulses = 0;
    got    = '0;
    for (int i = 0; i < 30; i++) begin
      if (i >= 3 && i < 8) begin
        st        = 1'b1;
        product_i = 8'hFF;
      end else begin
        st = 1'b0;
      end
      step();
      if (done) begin
        pulses++;
        got = bcd_o;
      end
    end
    check("midconv_pulses", pulses, 32'd1);
    check("midconv_bcd", 32'(got), 32'h042);
    check("midconv_idle", 32'(busy), 32'd0);

    // Reset at clock 8 of a conversion aborts it.
    product_i = 8'hE1;
    st        = 1'b1;
    step();
    st = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd_o), 32'h000);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done) pulses++;
    end
    check("abort_no_pulse", pulses, 32'd0);
    check("abort_bcd_held", 32'(bcd_o), 32'h000);
    exp_q.push_back(12'h123);
    run_conv(8'h7B, "after_abort");

    // Reset wins over st in the same cycle.
    product_i = 8'h55;
    st        = 1'b1;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    st  = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_bcd", 32'(bcd_o), 32'h000);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) pulses++;
    end
    check("rst_prio_no_pulse", pulses, 32'd0);

    // Random values against the reference.
    for (int i = 0; i < 40; i++) begin
      rv = 8'($urandom_range(0, 255));
      exp_q.push_back(ref_bcd(int'(rv)));
      run_conv(rv, $sformatf("rand%0d_%0d", i, rv));
    end

    // Exhaustive sweep.
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back(ref_bcd(v));
      run_conv(8'(v), $sformatf("sweep%0d", v));
    end

    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
